pwm_cfg_scheduler: RTL and testbench

PWM_CFG_SCHEDULER -- requirements
Module: pwm_cfg_scheduler

---
 rtl/pwm_cfg_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_pwm_cfg_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_scheduler.sv
// Queues decoded SPI register writes and applies them one at a time to the active
// PWM configuration registers; duty-cycle updates wait for the next PWM period boundary.
module pwm_cfg_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_ADDR   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       period_end,
  input  logic       err_clr,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [4:0] fifo_count,
  output logic       busy,
  output logic       err_addr,
  output logic       overflow
);

  localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]       DEPTH_C    = 5'(FIFO_DEPTH);
  localparam logic [6:0]       MAX_ADDR_C = 7'(MAX_ADDR);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_APPLY      = 2'd1,
    ST_WAIT_BOUND = 2'd2
  } state_t;

  state_t           state_r;
  logic [6:0]       q_addr_r [FIFO_DEPTH];
  logic [7:0]       q_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [4:0]       count_r;
  logic [6:0]       cap_addr_r;
  logic [7:0]       cap_data_r;
  logic [7:0]       shadow_r;
  logic [7:0]       reg_out_lo_r;
  logic [7:0]       reg_out_hi_r;
  logic [7:0]       reg_pwm_lo_r;
  logic [7:0]       reg_pwm_hi_r;
  logic [7:0]       duty_r;
  logic             err_addr_r;
  logic             overflow_r;

  logic             ready_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             addr_bad_s;
  logic             drop_s;

  // Handshake decode: acceptance, address screening, drop detection and head pop
  always_comb begin
    ready_s    = 1'b0;
    accept_s   = 1'b0;
    addr_bad_s = 1'b0;
    push_s     = 1'b0;
    drop_s     = 1'b0;
    pop_s      = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else begin
      ready_s    = (count_r < DEPTH_C);
      accept_s   = wr_valid && ready_s;
      addr_bad_s = accept_s && (wr_addr > MAX_ADDR_C);
      push_s     = accept_s && !addr_bad_s;
      drop_s     = wr_valid && !ready_s;
      pop_s      = (state_r == ST_IDLE) && (count_r != 5'd0);
    end
  end

  // Pending-write queue storage and pointers; a push never lands on a full queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 5'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_addr_r[i] <= 7'd0;
        q_data_r[i] <= 8'd0;
      end
    end else begin
      if (push_s) begin
        q_addr_r[wr_ptr_r] <= wr_addr;
        q_data_r[wr_ptr_r] <= wr_data;
        wr_ptr_r           <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Apply sequencer: pop head, write the target register, hold duty writes for a boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cap_addr_r   <= 7'd0;
      cap_data_r   <= 8'd0;
      shadow_r     <= 8'd0;
      reg_out_lo_r <= 8'd0;
      reg_out_hi_r <= 8'd0;
      reg_pwm_lo_r <= 8'd0;
      reg_pwm_hi_r <= 8'd0;
      duty_r       <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            cap_addr_r <= q_addr_r[rd_ptr_r];
            cap_data_r <= q_data_r[rd_ptr_r];
            state_r    <= ST_APPLY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          case (cap_addr_r)
            7'd0: begin
              reg_out_lo_r <= cap_data_r;
              state_r      <= ST_IDLE;
            end
            7'd1: begin
              reg_out_hi_r <= cap_data_r;
              state_r      <= ST_IDLE;
            end
            7'd2: begin
              reg_pwm_lo_r <= cap_data_r;
              state_r      <= ST_IDLE;
            end
            7'd3: begin
              reg_pwm_hi_r <= cap_data_r;
              state_r      <= ST_IDLE;
            end
            7'd4: begin
              shadow_r <= cap_data_r;
              state_r  <= ST_WAIT_BOUND;
            end
            // Addresses without a backing register are discarded.
            default: state_r <= ST_IDLE;
          endcase
        end
        ST_WAIT_BOUND: begin
          if (period_end) begin
            duty_r  <= shadow_r;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_BOUND;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error event takes priority over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (addr_bad_s) begin
        err_addr_r <= 1'b1;
      end else if (err_clr) begin
        err_addr_r <= 1'b0;
      end else begin
        err_addr_r <= err_addr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign wr_ready        = ready_s;
  assign en_reg_out_7_0  = reg_out_lo_r;
  assign en_reg_out_15_8 = reg_out_hi_r;
  assign en_reg_pwm_7_0  = reg_pwm_lo_r;
  assign en_reg_pwm_15_8 = reg_pwm_hi_r;
  assign pwm_duty_cycle  = duty_r;
  assign fifo_count      = count_r;
  assign busy            = (state_r != ST_IDLE) || (count_r != 5'd0);
  assign err_addr        = err_addr_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Self-checking bench for pwm_cfg_scheduler: a scoreboard of expected register
// updates is consumed by a monitor that watches the five active registers.
module tb_pwm_cfg_scheduler;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       period_end;
  logic       err_clr;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [4:0] fifo_count;
  logic       busy;
  logic       err_addr;
  logic       overflow;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cur  [5];
  logic [7:0] prev [5];
  logic       rst_edge;

  pwm_cfg_scheduler #(.FIFO_DEPTH(4), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .period_end(period_end), .err_clr(err_clr),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .fifo_count(fifo_count), .busy(busy),
    .err_addr(err_addr), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur[0] = en_reg_out_7_0;
  assign cur[1] = en_reg_out_15_8;
  assign cur[2] = en_reg_pwm_7_0;
  assign cur[3] = en_reg_pwm_15_8;
  assign cur[4] = pwm_duty_cycle;

  always @(posedge clk) rst_edge <= rst;

  // Monitor: every register change must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_edge === 1'b1 || rst === 1'b1) begin
      for (int i = 0; i < 5; i++) prev[i] = cur[i];
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (cur[i] !== prev[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_update: reg%0d became %h, expected no change", i, cur[i]);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.addr !== 3'(i) || mon_e.data !== cur[i]) begin
              errors++;
              $display("FAIL apply_order: got reg%0d=%h, expected reg%0d=%h",
                       i, cur[i], mon_e.addr, mon_e.data);
            end
          end
          prev[i] = cur[i];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input bit expect_apply);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    if (expect_apply) exp_q.push_back('{addr: a[2:0], data: d});
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_period_end();
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries pending after %0d cycles, expected 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_addr = 7'd0; wr_data = 8'd0;
    period_end = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    do_write(7'd0, 8'hFF, 1'b0);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", wr_ready); end
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 5'd0) begin
      errors++; $display("FAIL reset_write_ignored: overflow=%b count=%0d expected 0/0", overflow, fifo_count);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cur[i] !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h expected 00", i, cur[i]); end
    end
    checks++;
    if (fifo_count !== 5'd0 || busy !== 1'b0 || err_addr !== 1'b0 || overflow !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: count=%0d busy=%b err=%b ovf=%b rdy=%b expected 0 0 0 0 1",
               fifo_count, busy, err_addr, overflow, wr_ready);
    end
  endtask

  task automatic test_basic_latency();
    do_write(7'd0, 8'hA5, 1'b1);
    checks++;
    if (fifo_count !== 5'd1 || en_reg_out_7_0 !== 8'h00) begin
      errors++; $display("FAIL lat_e0: count=%0d reg=%h expected 1/00", fifo_count, en_reg_out_7_0);
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 5'd0 || busy !== 1'b1 || en_reg_out_7_0 !== 8'h00) begin
      errors++; $display("FAIL lat_e1: count=%0d busy=%b reg=%h expected 0/1/00", fifo_count, busy, en_reg_out_7_0);
    end
    @(negedge clk);
    checks++;
    if (en_reg_out_7_0 !== 8'hA5 || busy !== 1'b0) begin
      errors++; $display("FAIL lat_e2: reg=%h busy=%b expected a5/0", en_reg_out_7_0, busy);
    end
  endtask

  task automatic test_duty_boundary();
    pulse_period_end();
    do_write(7'd4, 8'h80, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (pwm_duty_cycle !== 8'h00 || busy !== 1'b1) begin
      errors++; $display("FAIL duty_hold: duty=%h busy=%b expected 00/1", pwm_duty_cycle, busy);
    end
    pulse_period_end();
    checks++;
    if (pwm_duty_cycle !== 8'h80 || busy !== 1'b0) begin
      errors++; $display("FAIL duty_apply: duty=%h busy=%b expected 80/0", pwm_duty_cycle, busy);
    end
  endtask

  task automatic test_overflow();
    do_write(7'd4, 8'h11, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) do_write(7'(i), 8'h31 + 8'(i), 1'b1);
    do_write(7'd0, 8'hEE, 1'b0);
    checks++;
    if (overflow !== 1'b1 || wr_ready !== 1'b0 || fifo_count !== 5'd4) begin
      errors++; $display("FAIL ovf_full: ovf=%b rdy=%b count=%0d expected 1/0/4", overflow, wr_ready, fifo_count);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    err_clr = 1'b1;
    do_write(7'd0, 8'hEF, 1'b0);
    err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    pulse_period_end();
    wait_drain(40);
    @(negedge clk);
    checks++;
    if (en_reg_out_7_0 !== 8'h31 || en_reg_out_15_8 !== 8'h32 || en_reg_pwm_7_0 !== 8'h33 ||
        en_reg_pwm_15_8 !== 8'h34 || pwm_duty_cycle !== 8'h11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain: regs=%h %h %h %h duty=%h busy=%b expected 31 32 33 34 11 0",
               en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, busy);
    end
  endtask

  task automatic test_bad_addr();
    do_write(7'd7, 8'h5C, 1'b0);
    checks++;
    if (err_addr !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_addr: err=%b count=%0d busy=%b expected 1/0/0", err_addr, fifo_count, busy);
    end
    err_clr = 1'b1;
    do_write(7'd100, 8'h5D, 1'b0);
    err_clr = 1'b0;
    checks++;
    if (err_addr !== 1'b1) begin errors++; $display("FAIL bad_addr_set_wins: got %b expected 1", err_addr); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err_addr !== 1'b0 || fifo_count !== 5'd0) begin
      errors++; $display("FAIL bad_addr_clear: err=%b count=%0d expected 0/0", err_addr, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    do_write(7'd4, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) do_write(7'(i), 8'h60 + 8'(i), 1'b0);
    checks++;
    if (fifo_count !== 5'd3) begin errors++; $display("FAIL mid_queued: count=%0d expected 3", fifo_count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (fifo_count !== 5'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset: count=%0d busy=%b ovf=%b expected 0/0/0", fifo_count, busy, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cur[i] !== 8'h00) begin errors++; $display("FAIL mid_reset_reg%0d: got %h expected 00", i, cur[i]); end
    end
    pulse_period_end();
    repeat (10) @(negedge clk);
    checks++;
    if (pwm_duty_cycle !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_discard: duty=%h busy=%b expected 00/0", pwm_duty_cycle, busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_write(7'(i), 8'hC1 + 8'(i), 1'b1);
    checks++;
    if (fifo_count !== 5'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", fifo_count); end
    repeat (4) @(negedge clk);
    checks++;
    if (en_reg_pwm_7_0 !== 8'hC3 || en_reg_pwm_15_8 !== 8'h00) begin
      errors++; $display("FAIL b2b_rate_e7: pwm_lo=%h pwm_hi=%h expected c3/00", en_reg_pwm_7_0, en_reg_pwm_15_8);
    end
    @(negedge clk);
    checks++;
    if (en_reg_pwm_15_8 !== 8'hC4 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_rate_e8: pwm_hi=%h busy=%b expected c4/0", en_reg_pwm_15_8, busy);
    end
    wait_drain(10);
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_duty_boundary();
    test_overflow();
    test_bad_addr();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
